// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } rx_state_t;

  localparam logic [15:0] DEFAULT_BAUD_DIV = 16'd868;
  localparam int          UART_DATA_BITS   = 8;

endpackage

// File: rtl/uart_rx_core.sv
// Serial front end: two-flop synchroniser, frame FSM and bit timing.
// Emits a one-cycle rx_valid_o with the assembled byte, or frame_err_o
// when the stop bit is found low.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int B = UART_DATA_BITS
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [15:0]  baud_div_i,
  input  logic         rx_active_i,
  input  logic         rx_i,
  output logic [B-1:0] rx_byte_o,
  output logic         rx_valid_o,
  output logic         frame_err_o
);

  localparam int IW = (B > 1) ? $clog2(B) : 1;

  logic          rxMeta_q, rxs_q;
  rx_state_t     state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   div_q, div_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [B-1:0]  shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  // Bring the asynchronous line into the clock domain; preset high so reset looks like an idle line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rxMeta_q <= 1'b1;
      rxs_q    <= 1'b1;
    end else begin
      rxMeta_q <= rx_i;
      rxs_q    <= rxMeta_q;
    end
  end

  // Frame state, bit timing and assembled byte.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      div_q   <= 16'd0;
      idx_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic; the bit period is frozen at START entry so mid-frame baud changes are ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    div_d   = div_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (!rx_active_i) begin
      state_d = IDLE;
      cnt_d   = 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = 16'd0;
          if (!rxs_q) begin
            state_d = START;
            div_d   = baud_div_i;
          end
        end
        START: begin
          if (cnt_q == (div_q >> 1)) begin
            cnt_d = 16'd0;
            idx_d = '0;
            if (rxs_q) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
            end
          end
        end
        DATA: begin
          if (cnt_q == div_q - 16'd1) begin
            shift_d = {rxs_q, shift_q[B-1:1]};
            cnt_d   = 16'd0;
            idx_d   = idx_q + IW'(1);
            if (idx_q == IW'(B - 1)) begin
              state_d = STOP;
            end
          end
        end
        STOP: begin
          if (cnt_q == div_q - 16'd1) begin
            cnt_d = 16'd0;
            if (rxs_q) begin
              valid_d = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = WAIT_HI;
            end
          end
        end
        WAIT_HI: begin
          cnt_d = 16'd0;
          if (rxs_q) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end
      endcase
    end
  end

  assign rx_byte_o   = shift_q;
  assign rx_valid_o  = valid_q;
  assign frame_err_o = ferr_q;

endmodule

// File: rtl/uart_rx_top.sv
// UART receiver: serial core feeding a 2**W-deep first-word-fall-through
// FIFO, with sticky overrun/framing flags for the status register.
module uart_rx_top
  import uart_pkg::*;
#(
  parameter int W = 5,
  parameter int B = UART_DATA_BITS
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [15:0]  baud_div,
  input  logic         UART_Control_Register_rx_Active,
  input  logic         UART_Data_Read_Register_enable,
  output logic [B-1:0] UART_Data_Read_Register_rdata,
  output logic         UART_Status_Register_rx_full,
  output logic         UART_Status_Register_rx_empty,
  output logic         UART_Status_Register_overrun,
  output logic         UART_Status_Register_frame_err,
  input  logic         UART_Status_Clear,
  input  logic         UART_rx_i,
  output logic         UART_Data_Receive_Tick
);

  localparam int DEPTH = 2 ** W;

  logic [B-1:0] rxByte;
  logic         rxValid, frameErrPulse;

  logic [B-1:0] mem_q [DEPTH];
  logic [W-1:0] wrPtr_q, rdPtr_q;
  logic [W:0]   count_q;
  logic         overrun_q, frameErr_q;
  logic         full, empty, popEn, wrEn, dropEn;

  uart_rx_core #(.B(B)) u_core (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .baud_div_i  (baud_div),
    .rx_active_i (UART_Control_Register_rx_Active),
    .rx_i        (UART_rx_i),
    .rx_byte_o   (rxByte),
    .rx_valid_o  (rxValid),
    .frame_err_o (frameErrPulse)
  );

  // A pop frees a slot in the same cycle, so a write to a full FIFO still lands when popped together.
  assign full   = (count_q == (W+1)'(DEPTH));
  assign empty  = (count_q == '0);
  assign popEn  = UART_Data_Read_Register_enable & ~empty;
  assign wrEn   = rxValid & (~full | popEn);
  assign dropEn = rxValid & full & ~popEn;

  // Storage array; contents need no reset because the count gates every read.
  always_ff @(posedge clk_i) begin
    if (wrEn) begin
      mem_q[wrPtr_q] <= rxByte;
    end
  end

  // Pointers wrap naturally at 2**W; the extra count bit distinguishes full from empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (wrEn) begin
        wrPtr_q <= wrPtr_q + W'(1);
      end
      if (popEn) begin
        rdPtr_q <= rdPtr_q + W'(1);
      end
      case ({wrEn, popEn})
        2'b10:   count_q <= count_q + (W+1)'(1);
        2'b01:   count_q <= count_q - (W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags; a new event takes priority over a same-cycle clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overrun_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      if (dropEn) begin
        overrun_q <= 1'b1;
      end else if (UART_Status_Clear) begin
        overrun_q <= 1'b0;
      end
      if (frameErrPulse) begin
        frameErr_q <= 1'b1;
      end else if (UART_Status_Clear) begin
        frameErr_q <= 1'b0;
      end
    end
  end

  assign UART_Data_Read_Register_rdata  = empty ? '0 : mem_q[rdPtr_q];
  assign UART_Status_Register_rx_full   = full;
  assign UART_Status_Register_rx_empty  = empty;
  assign UART_Status_Register_overrun   = overrun_q;
  assign UART_Status_Register_frame_err = frameErr_q;
  assign UART_Data_Receive_Tick         = wrEn;

endmodule

// File: tb/tb_uart_rx_top.sv
// Randomised bench for uart_rx_top: serial frames are generated here,
// a queue-based reference model predicts FIFO contents and flags, and a
// monitor scores every receive tick and every pop against it.
module tb_uart_rx_top;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] baudDiv = 16'd16;
  logic        rxActive = 1'b0;
  logic        rdEnable = 1'b0;
  logic        statusClear = 1'b0;
  logic        rxLine = 1'b1;
  logic [7:0]  rdata;
  logic        rxFull, rxEmpty, overrun, frameErr, rxTick;

  int comparisons = 0;
  int failures = 0;
  int cyc = 0;
  int lastTickCyc = -1;
  int frameStartCyc = 0;
  int expVal;
  int delta;

  logic [7:0] modelFifo[$];
  logic [7:0] expWr[$];
  int         expRd[$];
  bit         modelOverrun = 1'b0;
  bit         modelFerr = 1'b0;

  uart_rx_top #(.W(5), .B(8)) dut (
    .clk_i                           (clk),
    .rst_i                           (rst),
    .baud_div                        (baudDiv),
    .UART_Control_Register_rx_Active (rxActive),
    .UART_Data_Read_Register_enable  (rdEnable),
    .UART_Data_Read_Register_rdata   (rdata),
    .UART_Status_Register_rx_full    (rxFull),
    .UART_Status_Register_rx_empty   (rxEmpty),
    .UART_Status_Register_overrun    (overrun),
    .UART_Status_Register_frame_err  (frameErr),
    .UART_Status_Clear               (statusClear),
    .UART_rx_i                       (rxLine),
    .UART_Data_Receive_Tick          (rxTick)
  );

  // 10 ns system clock
  always #5 clk = ~clk;

  // Edge counter used for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    comparisons++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Compare all status outputs and the FIFO head against the model
  task automatic checkStatus(input string tag);
    @(negedge clk);
    checkOutput({tag, "_empty"}, int'(rxEmpty), (modelFifo.size() == 0) ? 1 : 0);
    checkOutput({tag, "_full"}, int'(rxFull), (modelFifo.size() == 32) ? 1 : 0);
    checkOutput({tag, "_overrun"}, int'(overrun), int'(modelOverrun));
    checkOutput({tag, "_frame_err"}, int'(frameErr), int'(modelFerr));
    checkOutput({tag, "_rdata"}, int'(rdata), (modelFifo.size() == 0) ? 0 : int'(modelFifo[0]));
  endtask

  // Drive one 8N1 frame; 'completes' says whether the receiver will see it to the end
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int div,
                               input int extraLow, input bit completes);
    if (completes) begin
      if (stopBit) begin
        if (modelFifo.size() < 32) begin
          modelFifo.push_back(data);
          expWr.push_back(data);
        end else begin
          modelOverrun = 1'b1;
        end
      end else begin
        modelFerr = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    baudDiv = 16'(div);
    rxLine = 1'b0;
    frameStartCyc = cyc;
    repeat (div) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rxLine = data[i];
      repeat (div) @(posedge clk);
      #1;
    end
    rxLine = stopBit;
    repeat (div * (1 + (stopBit ? 0 : extraLow))) @(posedge clk);
    #1;
    rxLine = 1'b1;
    if (!stopBit) begin
      repeat (div) @(posedge clk);
      #1;
    end
  endtask

  task automatic popByte();
    @(posedge clk);
    #1;
    rdEnable = 1'b1;
    if (modelFifo.size() > 0) expRd.push_back(int'(modelFifo.pop_front()));
    else expRd.push_back(-1);
    @(posedge clk);
    #1;
    rdEnable = 1'b0;
  endtask

  task automatic clearStatus();
    @(posedge clk);
    #1;
    statusClear = 1'b1;
    modelOverrun = 1'b0;
    modelFerr = 1'b0;
    @(posedge clk);
    #1;
    statusClear = 1'b0;
  endtask

  // Scoreboard monitor: every tick must match a predicted write, every pop a predicted head
  always @(negedge clk) begin
    if (!rst && rxTick) begin
      lastTickCyc = cyc;
      comparisons++;
      if (expWr.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_tick: got a receive tick, expected none");
      end else begin
        void'(expWr.pop_front());
      end
    end
    if (!rst && rdEnable) begin
      comparisons++;
      if (expRd.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_pop: pop seen with no prediction");
      end else begin
        expVal = expRd.pop_front();
        if (expVal < 0) begin
          if (!(rxEmpty && rdata == 8'h00)) begin
            failures++;
            $display("[TB] FAIL pop_empty: got rdata=%0h empty=%0b, expected rdata=0 empty=1",
                     rdata, rxEmpty);
          end
        end else if (rxEmpty || rdata != expVal[7:0]) begin
          failures++;
          $display("[TB] FAIL pop_data: got rdata=%0h empty=%0b, expected rdata=%0h empty=0",
                   rdata, rxEmpty, expVal[7:0]);
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] b;
    int         r;
    int         d;

    $display("[TB] reset");
    repeat (4) @(posedge clk);
    checkStatus("reset");
    #1;
    rst = 1'b0;
    rxActive = 1'b1;
    repeat (4) @(posedge clk);

    $display("[TB] single frame and latency");
    applyStimulus(8'hA5, 1'b1, 16, 0, 1'b1);
    delta = lastTickCyc - frameStartCyc;
    checkOutput("tick_latency_in_window", (delta >= 9 * 16 && delta <= 10 * 16) ? 1 : 0, 1);
    checkStatus("single");
    popByte();
    checkStatus("single_popped");

    $display("[TB] glitch");
    @(posedge clk);
    #1;
    rxLine = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rxLine = 1'b1;
    repeat (40) @(posedge clk);
    checkStatus("glitch");

    $display("[TB] framing error then recovery");
    applyStimulus(8'h3C, 1'b0, 16, 2, 1'b1);
    checkStatus("frame_err");
    applyStimulus(8'h5A, 1'b1, 16, 0, 1'b1);
    checkStatus("after_frame_err");
    clearStatus();
    checkStatus("cleared_ferr");
    popByte();

    $display("[TB] random traffic");
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      d = $urandom_range(12, 24);
      b = 8'($urandom);
      if (r <= 5) applyStimulus(b, 1'b1, d, 0, 1'b1);
      else if (r == 6) applyStimulus(b, 1'b0, d, $urandom_range(0, 2), 1'b1);
      else popByte();
    end
    checkStatus("random");
    while (modelFifo.size() > 0) popByte();
    clearStatus();
    checkStatus("random_drained");

    $display("[TB] fill and overrun");
    for (int n = 0; n < 32; n++) begin
      applyStimulus(8'($urandom), 1'b1, $urandom_range(12, 24), 0, 1'b1);
    end
    checkStatus("filled");
    applyStimulus(8'hFF, 1'b1, 16, 0, 1'b1);
    checkStatus("overrun");
    for (int n = 0; n < 32; n++) popByte();
    popByte();
    checkStatus("drained");
    clearStatus();
    checkStatus("overrun_cleared");

    $display("[TB] receiver disabled mid-frame");
    fork
      applyStimulus(8'h81, 1'b1, 16, 0, 1'b0);
      begin
        repeat (3 * 16) @(posedge clk);
        #1;
        rxActive = 1'b0;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    rxActive = 1'b1;
    checkStatus("abort");

    $display("[TB] reset mid-frame");
    applyStimulus(8'h11, 1'b1, 16, 0, 1'b1);
    applyStimulus(8'h22, 1'b1, 16, 0, 1'b1);
    fork
      applyStimulus(8'hC3, 1'b1, 16, 0, 1'b0);
      begin
        repeat (5 * 16) @(posedge clk);
        #1;
        rst = 1'b1;
        modelFifo.delete();
        expWr.delete();
        modelOverrun = 1'b0;
        modelFerr = 1'b0;
      end
    join
    checkStatus("in_reset");
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    applyStimulus(8'h96, 1'b1, 20, 0, 1'b1);
    checkStatus("after_reset");
    popByte();
    checkStatus("final");

    repeat (4) @(posedge clk);
    checkOutput("pending_ticks", expWr.size(), 0);
    checkOutput("pending_pops", expRd.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", comparisons, failures);
    $finish;
  end

endmodule
